// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexes a sign position and three digit positions onto one shared
// active-low segment bus. Each slot lasts CLK_DIV clocks and starts with
// BLANK_CYC clocks of all-digits-off so that segment data never ghosts onto a
// neighbouring digit. The digit inputs are captured once per frame, so a frame
// always shows one consistent value. Optional leading-zero blanking darkens
// the hundreds digit, and then the tens digit, when they are zero.

module seg7_scan_driver #(
  parameter int unsigned CLK_DIV   = 50000,
  parameter int unsigned BLANK_CYC = 500,
  parameter bit          BLANK_LZ  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] hundreds_7segment,
  input  logic [6:0] tens_7segment,
  input  logic [6:0] units_7segment,
  input  logic       sign,
  output logic [6:0] seg_out,
  output logic [3:0] digit_en_n,
  output logic       frame_tick
);

  // Prescaler width. A width of at least one bit keeps the degenerate case legal.
  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  // Active-low segment patterns (bit0 = a .. bit6 = g).
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;

  // Active-low digit enables, [3]=sign .. [0]=units.
  localparam logic [3:0] EN_NONE = 4'hF;
  localparam logic [3:0] EN_SIGN = 4'b0111;
  localparam logic [3:0] EN_HUND = 4'b1011;
  localparam logic [3:0] EN_TENS = 4'b1101;
  localparam logic [3:0] EN_UNIT = 4'b1110;

  typedef enum logic [1:0] {
    S_SIGN = 2'd0,
    S_HUND = 2'd1,
    S_TENS = 2'd2,
    S_UNIT = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // One-hot active-low enable for the digit owned by a slot.
  function automatic logic [3:0] slot_enable(input state_t st);
    logic [3:0] en;
    case (st)
      S_SIGN:  en = EN_SIGN;
      S_HUND:  en = EN_HUND;
      S_TENS:  en = EN_TENS;
      S_UNIT:  en = EN_UNIT;
      default: en = EN_NONE;
    endcase
    return en;
  endfunction

  // Pattern shown in a slot, including leading-zero suppression. The tens
  // digit is only suppressed when the hundreds digit was suppressed too, so
  // an interior zero (e.g. 105) is always drawn. Units are never suppressed.
  function automatic logic [6:0] slot_pattern(
    input state_t     st,
    input logic       neg,
    input logic [6:0] hund,
    input logic [6:0] tens,
    input logic [6:0] units
  );
    logic       hund_dark;
    logic       tens_dark;
    logic [6:0] pat;
    hund_dark = (BLANK_LZ == 1'b1) && (hund == SEG_ZERO);
    tens_dark = hund_dark && (tens == SEG_ZERO);
    case (st)
      S_SIGN:  pat = neg ? SEG_MINUS : SEG_BLANK;
      S_HUND:  pat = hund_dark ? SEG_BLANK : hund;
      S_TENS:  pat = tens_dark ? SEG_BLANK : tens;
      S_UNIT:  pat = units;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap_s;
  state_t           state_q, state_d;

  // Set by reset so that the very first edge afterwards captures the inputs.
  logic             first_q, first_d;
  logic             load_s;

  logic             snap_sign_q, snap_sign_d;
  logic [6:0]       snap_hund_q, snap_hund_d;
  logic [6:0]       snap_tens_q, snap_tens_d;
  logic [6:0]       snap_units_q, snap_units_d;

  logic             blank_s;
  logic [6:0]       seg_out_q, seg_out_d;
  logic [3:0]       digit_en_n_q, digit_en_n_d;
  logic             frame_tick_q, frame_tick_d;

  // ---------------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------------

  // Slot prescaler: counts 0..CLK_DIV-1 and flags the wrapping edge.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_s = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d  = CNT_ZERO;
      wrap_s = 1'b1;
    end else begin
      cnt_d  = cnt_q + CNT_ONE;
      wrap_s = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan FSM (state register / next state / outputs)
  // ---------------------------------------------------------------------------

  // State register: prescaler, slot state and the post-reset capture flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= CNT_ZERO;
      state_q <= S_SIGN;
      first_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      first_q <= first_d;
    end
  end

  // Next-state logic: step to the following slot only when the prescaler wraps.
  always_comb begin
    state_d = state_q;
    first_d = 1'b0;
    if (wrap_s) begin
      case (state_q)
        S_SIGN:  state_d = S_HUND;
        S_HUND:  state_d = S_TENS;
        S_TENS:  state_d = S_UNIT;
        S_UNIT:  state_d = S_SIGN;
        default: state_d = S_SIGN;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Snapshot capture: at the start of every frame and on the first edge after reset.
  always_comb begin
    load_s       = first_q | (wrap_s & (state_q == S_UNIT));
    snap_sign_d  = snap_sign_q;
    snap_hund_d  = snap_hund_q;
    snap_tens_d  = snap_tens_q;
    snap_units_d = snap_units_q;
    if (load_s) begin
      snap_sign_d  = sign;
      snap_hund_d  = hundreds_7segment;
      snap_tens_d  = tens_7segment;
      snap_units_d = units_7segment;
    end else begin
      snap_sign_d  = snap_sign_q;
      snap_hund_d  = snap_hund_q;
      snap_tens_d  = snap_tens_q;
      snap_units_d = snap_units_q;
    end
  end

  // Snapshot registers: reset to a positive, fully dark value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_sign_q  <= 1'b0;
      snap_hund_q  <= SEG_BLANK;
      snap_tens_q  <= SEG_BLANK;
      snap_units_q <= SEG_BLANK;
    end else begin
      snap_sign_q  <= snap_sign_d;
      snap_hund_q  <= snap_hund_d;
      snap_tens_q  <= snap_tens_d;
      snap_units_q <= snap_units_d;
    end
  end

  // Blanking window: the first BLANK_CYC counts of every slot keep all digits off.
  generate
    if (BLANK_CYC > 0) begin : g_blank
      localparam logic [CNT_W-1:0] BLANK_V = CNT_W'(BLANK_CYC);
      assign blank_s = (cnt_d < BLANK_V);
    end else begin : g_no_blank
      assign blank_s = 1'b0;
    end
  endgenerate

  // Output logic: decoded from the post-edge slot and snapshot so the
  // registered outputs line up exactly with the new prescaler value.
  always_comb begin
    digit_en_n_d = EN_NONE;
    seg_out_d    = SEG_BLANK;
    frame_tick_d = load_s;
    if (blank_s) begin
      digit_en_n_d = EN_NONE;
      seg_out_d    = SEG_BLANK;
    end else begin
      digit_en_n_d = slot_enable(state_d);
      seg_out_d    = slot_pattern(state_d, snap_sign_d, snap_hund_d,
                                  snap_tens_d, snap_units_d);
    end
  end

  // Output registers: a single flop per bit, so enables can never glitch multi-low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_out_q    <= SEG_BLANK;
      digit_en_n_q <= EN_NONE;
      frame_tick_q <= 1'b0;
    end else begin
      seg_out_q    <= seg_out_d;
      digit_en_n_q <= digit_en_n_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg_out    = seg_out_q;
  assign digit_en_n = digit_en_n_q;
  assign frame_tick = frame_tick_q;

endmodule
